// File: rtl/aes_block_tx_packer.sv
// aes_block_tx_packer
//   Feeds one AES result block into the I2C slave TX FIFO. The block is
//   accepted over a valid/ready handshake. An optional header byte goes out
//   first, then the block bytes follow, most significant byte first. At most
//   one byte is pushed per cycle, and a byte is only pushed while the FIFO is
//   not full, so no byte is ever lost.
//
// Ports
//   clk          system clock
//   n_rst        asynchronous active-low reset
//   block_valid  upstream block available
//   block_data   block payload, top byte sent first
//   block_ready  packer is idle and captures block_data on this edge
//   fifo_full    TX FIFO full flag
//   write_enable push write_data into the TX FIFO this cycle
//   write_data   byte presented to the TX FIFO (0 while idle)
//   busy         a block is captured and not yet fully pushed
//   block_done   one-cycle pulse in the first idle cycle after a block
module aes_block_tx_packer #(
    parameter int         SEND_HEADER = 1,
    parameter logic [7:0] HEADER_BYTE = 8'hA5,
    parameter int         NUM_BYTES   = 16
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   block_valid,
    input  logic [8*NUM_BYTES-1:0] block_data,
    output logic                   block_ready,
    input  logic                   fifo_full,
    output logic                   write_enable,
    output logic [7:0]             write_data,
    output logic                   busy,
    output logic                   block_done
);

    localparam int BLOCK_W = 8 * NUM_BYTES;
    localparam int CNT_W   = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        SEND   = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   byte_cnt;
    logic [BLOCK_W-1:0] shift_reg;

    // All handshake outputs decode directly from the state register, so
    // block_valid never reaches write_enable combinationally. Only fifo_full
    // gates the push in the same cycle, which keeps full-FIFO writes impossible.
    assign busy         = (state != IDLE);
    assign block_ready  = (state == IDLE);
    assign write_enable = ((state == HEADER) || (state == SEND)) && !fifo_full;

    always_comb begin
        write_data = 8'h00;
        case (state)
            HEADER:  write_data = HEADER_BYTE;
            SEND:    write_data = shift_reg[BLOCK_W-1 -: 8];
            default: write_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            byte_cnt   <= '0;
            shift_reg  <= '0;
            block_done <= 1'b0;
        end else begin
            block_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (block_valid) begin
                        shift_reg <= block_data;
                        byte_cnt  <= '0;
                        state     <= (SEND_HEADER != 0) ? HEADER : SEND;
                    end
                end
                HEADER: begin
                    if (!fifo_full) begin
                        state <= SEND;
                    end
                end
                SEND: begin
                    // A stalled cycle leaves counter and shift register
                    // untouched, so the same byte stays on write_data.
                    if (!fifo_full) begin
                        shift_reg <= shift_reg << 8;
                        if (byte_cnt == LAST_IDX) begin
                            byte_cnt   <= '0;
                            state      <= IDLE;
                            block_done <= 1'b1;
                        end else begin
                            byte_cnt <= byte_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_block_tx_packer.sv
module tb_aes_block_tx_packer;

    logic         clk = 1'b0;
    logic         n_rst;
    logic         block_valid;
    logic [127:0] block_data;
    logic         block_ready;
    logic         fifo_full;
    logic         write_enable;
    logic [7:0]   write_data;
    logic         busy;
    logic         block_done;

    // Second instance: no header, 4-byte blocks
    logic         nh_valid;
    logic [31:0]  nh_data;
    logic         nh_ready;
    logic         nh_full;
    logic         nh_we;
    logic [7:0]   nh_wd;
    logic         nh_busy;
    logic         nh_done;

    int checks = 0;
    int fails  = 0;

    // Reference model: the packer holds a list of bytes still to send.
    // It is busy exactly while that list is non-empty.
    logic [7:0] exp_q[$];
    logic       done_exp = 1'b0;
    int         push_cnt = 0;

    always #5 clk = ~clk;

    aes_block_tx_packer dut (
        .clk(clk), .n_rst(n_rst), .block_valid(block_valid), .block_data(block_data),
        .block_ready(block_ready), .fifo_full(fifo_full), .write_enable(write_enable),
        .write_data(write_data), .busy(busy), .block_done(block_done)
    );

    aes_block_tx_packer #(.SEND_HEADER(0), .HEADER_BYTE(8'hA5), .NUM_BYTES(4)) dut_nh (
        .clk(clk), .n_rst(n_rst), .block_valid(nh_valid), .block_data(nh_data),
        .block_ready(nh_ready), .fifo_full(nh_full), .write_enable(nh_we),
        .write_data(nh_wd), .busy(nh_busy), .block_done(nh_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [127:0] b);
        exp_q.push_back(8'hA5);
        for (int i = 0; i < 16; i++) exp_q.push_back(b[127-8*i -: 8]);
    endtask

    // One clock: compare at the falling edge, advance the model, then return
    // just after the rising edge so the caller can drive the next inputs.
    task automatic cycle();
        bit idle;
        bit push;
        @(negedge clk);
        idle = (exp_q.size() == 0);
        check("block_ready", block_ready, idle);
        check("busy", busy, !idle);
        check("block_done", block_done, done_exp);
        check("write_enable", write_enable, !idle && !fifo_full);
        check("write_data", write_data, idle ? 8'h00 : exp_q[0]);
        push = !idle && !fifo_full;
        done_exp = 1'b0;
        if (push) begin
            void'(exp_q.pop_front());
            push_cnt++;
            if (exp_q.size() == 0) done_exp = 1'b1;
        end else if (idle && block_valid) begin
            load(block_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_block(input logic [127:0] b);
        block_valid = 1'b1;
        block_data  = b;
        cycle();
        block_valid = 1'b0;
        block_data  = {4{$urandom()}};
    endtask

    // mode 0: never full, 1: alternate full starting high, 2: random full
    task automatic drain(input int mode);
        int n = 0;
        fifo_full = (mode == 1);
        while (exp_q.size() != 0 && n < 200) begin
            cycle();
            n++;
            if (mode == 1) fifo_full = ~fifo_full;
            else if (mode == 2) fifo_full = ($urandom_range(0, 2) == 0);
            else fifo_full = 1'b0;
        end
        check("drain_timeout", exp_q.size(), 0);
        fifo_full = 1'b0;
        cycle();
    endtask

    initial begin
        logic [127:0] b0;
        logic [7:0]   got[$];
        int           start;
        int           n;

        b0          = 128'h00112233445566778899AABBCCDDEEFF;
        n_rst       = 1'b0;
        block_valid = 1'b0;
        block_data  = '0;
        fifo_full   = 1'b0;
        nh_valid    = 1'b0;
        nh_data     = '0;
        nh_full     = 1'b0;

        #2;
        check("rst_ready", block_ready, 1);
        check("rst_we", write_enable, 0);
        check("rst_data", write_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", block_done, 0);
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        cycle();

        // Basic block
        start = push_cnt;
        send_block(b0);
        drain(0);
        check("basic_count", push_cnt - start, 17);

        // Backpressure at the 4th data byte (0x33)
        start = push_cnt;
        send_block(b0);
        n = 0;
        while (!(exp_q.size() == 13 && exp_q[0] == 8'h33) && n < 40) begin
            cycle();
            n++;
        end
        check("bp_reach_33", exp_q.size(), 13);
        fifo_full = 1'b1;
        repeat (5) cycle();
        check("bp_held_data", write_data, 8'h33);
        fifo_full = 1'b0;
        drain(0);
        check("bp_count", push_cnt - start, 17);

        // Alternating full
        start = push_cnt;
        send_block(b0);
        drain(1);
        check("alt_count", push_cnt - start, 17);

        // Back-to-back with garbage on block_data while busy
        start = push_cnt;
        block_valid = 1'b1;
        block_data  = 128'h1;
        cycle();
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            block_data = {4{$urandom()}};
            cycle();
            n++;
        end
        block_data = ~128'h1;
        cycle();
        check("b2b_capture_in_done", exp_q.size(), 17);
        block_valid = 1'b0;
        drain(2);
        check("b2b_count", push_cnt - start, 34);

        // Random blocks, random backpressure and idle gaps
        for (int k = 0; k < 6; k++) begin
            start = push_cnt;
            repeat ($urandom_range(0, 2)) cycle();
            send_block({$urandom(), $urandom(), $urandom(), $urandom()});
            drain(2);
            check("rand_count", push_cnt - start, 17);
        end

        // No-header instance
        nh_valid = 1'b1;
        nh_data  = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        nh_valid = 1'b0;
        nh_data  = 32'h12345678;
        check("nh_busy", nh_busy, 1);
        n = 0;
        while (!nh_done && n < 12) begin
            @(negedge clk);
            if (nh_we) got.push_back(nh_wd);
            n++;
        end
        check("nh_done_seen", nh_done, 1);
        check("nh_count", got.size(), 4);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] ref_word;
            ref_word = 32'hDEADBEEF;
            check("nh_byte", (i < got.size()) ? got[i] : 8'hxx, ref_word[31-8*i -: 8]);
        end
        @(posedge clk);
        #1;
        cycle();

        // Reset mid-block after the 6th write
        start = push_cnt;
        send_block({$urandom(), $urandom(), $urandom(), $urandom()});
        n = 0;
        while (push_cnt - start < 6 && n < 40) begin
            cycle();
            n++;
        end
        check("mid_six_writes", push_cnt - start, 6);
        n_rst = 1'b0;
        #1;
        check("mid_rst_ready", block_ready, 1);
        check("mid_rst_we", write_enable, 0);
        check("mid_rst_data", write_data, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", block_done, 0);
        exp_q.delete();
        done_exp = 1'b0;
        #1;
        n_rst = 1'b1;
        cycle();
        cycle();
        start = push_cnt;
        send_block({16{8'h0F}});
        drain(0);
        check("post_rst_count", push_cnt - start, 17);

        $display("== %0d vectors applied, %0d miscompares ==", checks, fails);
        $finish;
    end

endmodule
